// File: rtl/fp_pkg.sv
// Shared fp16 definitions for the fp16->fp32 front end: element widths,
// the fp16 field layout and the serializer's word-holding states.
package fp_pkg;

    localparam int FP16_W        = 16;
    localparam int FP32_W        = 32;
    localparam int FP16_EXP_BIAS = 15;

    // IEEE half precision: 1 sign bit, 5 exponent bits, 10 mantissa bits.
    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

    // The serializer either has no word (EMPTY) or is walking the lanes of
    // the one word it holds (HOLD).
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fp16_stream_serializer.sv
// Splits packed words of LANES fp16 values into a stream of single fp16
// elements, lane 0 first, tagged with lane index, end-of-word and
// end-of-packet. A single word register is enough for full throughput
// because the next word is accepted in the cycle the last lane leaves.
module fp16_stream_serializer
    import fp_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int CNT_W  = $clog2(LANES + 1),
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES*FP16_W-1:0]   in_data_i,
    input  logic [CNT_W-1:0]          in_count_i,
    input  logic                      in_last_i,

    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [FP16_W-1:0]         out_data_o,
    output logic [LANE_W-1:0]         out_lane_o,
    output logic                      out_word_end_o,
    output logic                      out_last_o,

    output logic [31:0]               elem_cnt_o
);

    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    ser_state_e                  state_q,    state_d;
    fp16_t [LANES-1:0]           word_q,     word_d;
    logic  [LANE_W-1:0]          last_idx_q, last_idx_d;
    logic                        last_q,     last_d;
    logic  [LANE_W-1:0]          lane_q,     lane_d;
    logic  [31:0]                elem_cnt_q, elem_cnt_d;

    logic                        holding;
    logic                        at_last_lane;
    logic                        out_fire;
    logic                        word_done;
    logic                        in_ready;
    logic                        in_fire;
    logic  [CNT_W-1:0]           eff_cnt;
    logic  [LANE_W-1:0]          in_last_idx;

    // A count of zero means a full word, and anything past LANES is clamped,
    // so the stored value is the index of the last lane to emit.
    always_comb begin
        eff_cnt = in_count_i;
        if (in_count_i == '0 || in_count_i > LANES_C) begin
            eff_cnt = LANES_C;
        end
        in_last_idx = LANE_W'(eff_cnt - CNT_W'(1));
    end

    // Handshake decode; a new word may enter in the same cycle the last lane
    // of the held word is consumed, which gives the out_ready->in_ready
    // combinational path that keeps consecutive words bubble-free.
    always_comb begin
        holding      = (state_q == ST_HOLD);
        at_last_lane = (lane_q == last_idx_q);
        out_fire     = holding && out_ready_i;
        word_done    = out_fire && at_last_lane;
        in_ready     = !holding || word_done;
        in_fire      = in_valid_i && in_ready;
    end

    // Next-state: latch a word when one arrives, step through its lanes on
    // each consumed element, and fall back to EMPTY when nothing follows.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        last_idx_d = last_idx_q;
        last_d     = last_q;
        lane_d     = lane_q;
        elem_cnt_d = elem_cnt_q;

        if (out_fire) begin
            elem_cnt_d = elem_cnt_q + 32'd1;
        end

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d    = ST_HOLD;
                    word_d     = in_data_i;
                    last_idx_d = in_last_idx;
                    last_d     = in_last_i;
                    lane_d     = '0;
                end
            end
            ST_HOLD: begin
                if (out_fire) begin
                    if (!at_last_lane) begin
                        lane_d = lane_q + LANE_W'(1);
                    end else if (in_fire) begin
                        word_d     = in_data_i;
                        last_idx_d = in_last_idx;
                        last_d     = in_last_i;
                        lane_d     = '0;
                    end else begin
                        state_d = ST_EMPTY;
                        lane_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State registers; reset throws away any partly sent word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            word_q     <= '0;
            last_idx_q <= LANE_W'(LANES - 1);
            last_q     <= 1'b0;
            lane_q     <= '0;
            elem_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            last_idx_q <= last_idx_d;
            last_q     <= last_d;
            lane_q     <= lane_d;
            elem_cnt_q <= elem_cnt_d;
        end
    end

    // Outputs come straight from the registers, so the element seen by the
    // converter never depends on in_data_i within the same cycle.
    always_comb begin
        in_ready_o     = in_ready;
        out_valid_o    = holding;
        out_data_o     = word_q[lane_q];
        out_lane_o     = lane_q;
        out_word_end_o = holding && at_last_lane;
        out_last_o     = holding && at_last_lane && last_q;
        elem_cnt_o     = elem_cnt_q;
    end

endmodule
